// File: rtl/avg_arb.sv
// avg_arb: two-requester arbiter/sequencer for a shared two-bank moving-average datapath.
// Optional build macro AVG_ARB_STRICT_PRIO_EN selects strict channel-0 priority instead of round-robin.
module avg_arb #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SAMPLES = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [WIDTH-1:0] req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [WIDTH-1:0] req1_data_i,
  output logic             req1_ready_o,
  input  logic             flush_i,
  output logic             avg_clr_o,
  output logic             avg_ch_o,
  output logic [WIDTH-1:0] avg_data_o,
  output logic             avg_start_o,
  input  logic [WIDTH-1:0] avg_result_i,
  output logic             res_valid_o,
  output logic             res_ch_o,
  output logic [WIDTH-1:0] res_data_o,
  output logic             res_settled_o
);

  localparam int unsigned    CW  = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0]  SAT = CW'(SAMPLES);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_LOAD,
    S_START
  } state_t;

  state_t           state_q;
  logic             pend_q;
  logic [CW-1:0]    cnt0_q;
  logic [CW-1:0]    cnt1_q;
  logic             avg_ch_q;
  logic [WIDTH-1:0] avg_data_q;
  logic             res_valid_q;
  logic             res_ch_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_settled_q;

  logic             accept_ok;
  logic             sel1;
  logic             hs;
  logic [WIDTH-1:0] hs_data;
  logic [CW-1:0]    cnt_cur;
  logic [CW-1:0]    cnt_d;

  // Flush (pending or fresh) takes priority over any new handshake.
  assign accept_ok = (state_q == S_IDLE) && !pend_q && !flush_i;

`ifdef AVG_ARB_STRICT_PRIO_EN
  assign sel1 = req1_valid_i & ~req0_valid_i;
`else
  logic last_q;
  // With no valid request, ready0 stays up so a lone channel-0 sample is taken at once.
  assign sel1 = req1_valid_i & (~req0_valid_i | ~last_q);
`endif

  assign req0_ready_o = accept_ok & ~sel1;
  assign req1_ready_o = accept_ok &  sel1;
  assign hs           = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
  assign hs_data      = sel1 ? req1_data_i : req0_data_i;

  assign cnt_cur = avg_ch_q ? cnt1_q : cnt0_q;
  assign cnt_d   = (cnt_cur == SAT) ? cnt_cur : cnt_cur + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FLUSH;
      pend_q        <= 1'b0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      avg_ch_q      <= 1'b0;
      avg_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= 1'b0;
      res_data_q    <= '0;
      res_settled_q <= 1'b0;
`ifndef AVG_ARB_STRICT_PRIO_EN
      last_q        <= 1'b1;
`endif
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          cnt0_q  <= '0;
          cnt1_q  <= '0;
          pend_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (pend_q || flush_i) begin
            state_q <= S_FLUSH;
          end else if (hs) begin
            avg_data_q <= hs_data;
            avg_ch_q   <= sel1;
`ifndef AVG_ARB_STRICT_PRIO_EN
            last_q     <= sel1;
`endif
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (flush_i) pend_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          if (flush_i) pend_q <= 1'b1;
          res_data_q    <= avg_result_i;
          res_ch_q      <= avg_ch_q;
          res_settled_q <= (cnt_d == SAT);
          res_valid_q   <= 1'b1;
          if (avg_ch_q) cnt1_q <= cnt_d;
          else          cnt0_q <= cnt_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign avg_clr_o     = (state_q == S_FLUSH);
  assign avg_start_o   = (state_q == S_START);
  assign avg_ch_o      = avg_ch_q;
  assign avg_data_o    = avg_data_q;
  assign res_valid_o   = res_valid_q;
  assign res_ch_o      = res_ch_q;
  assign res_data_o    = res_data_q;
  assign res_settled_o = res_settled_q;

endmodule

// File: tb/tb_avg_arb.sv
// Self-checking bench for avg_arb: scoreboard of expected results keyed by handshakes,
// with a behavioural datapath that subtracts a fixed per-bank offset.
module tb_avg_arb;
  localparam int unsigned W = 16;
  localparam int unsigned N = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [W-1:0] req0_data_i = '0, req1_data_i = '0;
  logic         req0_ready_o, req1_ready_o;
  logic         flush_i = 1'b0;
  logic         avg_clr_o, avg_ch_o, avg_start_o;
  logic [W-1:0] avg_data_o, avg_result_i;
  logic         res_valid_o, res_ch_o, res_settled_o;
  logic [W-1:0] res_data_o;

  avg_arb #(.WIDTH(W), .SAMPLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .flush_i(flush_i),
    .avg_clr_o(avg_clr_o), .avg_ch_o(avg_ch_o), .avg_data_o(avg_data_o),
    .avg_start_o(avg_start_o), .avg_result_i(avg_result_i),
    .res_valid_o(res_valid_o), .res_ch_o(res_ch_o), .res_data_o(res_data_o),
    .res_settled_o(res_settled_o)
  );

  always #5 clk = ~clk;

  // Bank 0 has zero mean, bank 1 a DC level of 0x10; garbage outside the strobe.
  always_comb avg_result_i = avg_start_o ? (avg_data_o - (avg_ch_o ? 16'h0010 : 16'h0000)) : 16'hBAD0;

  typedef struct {
    logic         ch;
    logic [W-1:0] data;
    logic         settled;
    int           cyc;
  } exp_t;

  exp_t        sb[$];
  int          hs_ch[$];
  int          hs_cyc[$];
  int unsigned cnt_m[2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic ch, input logic [W-1:0] d);
    exp_t e;
    if (cnt_m[ch] < N) cnt_m[ch]++;
    e.ch      = ch;
    e.data    = d - (ch ? 16'h0010 : 16'h0000);
    e.settled = (cnt_m[ch] == N);
    e.cyc     = cyc + 3;
    sb.push_back(e);
    hs_ch.push_back(int'(ch));
    hs_cyc.push_back(cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      check("one_ready", 32'(req0_ready_o & req1_ready_o), 32'd0);
      if (req0_valid_i && req0_ready_o) push_exp(1'b0, req0_data_i);
      if (req1_valid_i && req1_ready_o) push_exp(1'b1, req1_data_i);
      if (res_valid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_ch", 32'(res_ch_o), 32'(e.ch));
          check("res_data", 32'(res_data_o), 32'(e.data));
          check("res_settled", 32'(res_settled_o), 32'(e.settled));
          check("res_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic feed(input logic ch, input int n, input logic [W-1:0] base);
    logic [W-1:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = base + 16'(i * 7);
      if (ch) begin req1_data_i = d; req1_valid_i = 1'b1; end
      else    begin req0_data_i = d; req0_valid_i = 1'b1; end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(ch ? req1_ready_o : req0_ready_o) && t < 100);
      if (t >= 100) begin
        check("feed_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    if (ch) req1_valid_i = 1'b0;
    else    req0_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clr"}, 32'(avg_clr_o), 32'd1);
    check({tag, "_start"}, 32'(avg_start_o), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
    check({tag, "_rdy"}, 32'({req0_ready_o, req1_ready_o}), 32'd0);
    check({tag, "_avg_data"}, 32'(avg_data_o), 32'd0);
    check({tag, "_avg_ch"}, 32'(avg_ch_o), 32'd0);
    check({tag, "_res_data"}, 32'(res_data_o), 32'd0);
    check({tag, "_res_ch"}, 32'({res_ch_o, res_settled_o}), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_clr_first", 32'(avg_clr_o), 32'd1);
    check("rel_no_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
    @(negedge clk);
    check("rel_clr_done", 32'(avg_clr_o), 32'd0);
    check("rel_ready0", 32'(req0_ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    cnt_m[0] = 0;
    cnt_m[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    release_reset();

    // Single ch0 sample, zero-mean bank.
    @(posedge clk); #1;
    req0_data_i = 16'h0100; req0_valid_i = 1'b1;
    @(negedge clk);
    check("single_ready0", 32'(req0_ready_o), 32'd1);
    @(posedge clk); #1 req0_valid_i = 1'b0;
    @(negedge clk);
    check("load_data", 32'(avg_data_o), 32'h0100);
    check("load_ch", 32'(avg_ch_o), 32'd0);
    check("load_no_start", 32'(avg_start_o), 32'd0);
    @(negedge clk);
    check("start_strobe", 32'(avg_start_o), 32'd1);
    check("start_data_held", 32'(avg_data_o), 32'h0100);
    drain();

    // Contention: ch0 was granted last, so round-robin opens with ch1.
    base = hs_ch.size();
    @(posedge clk); #1;
    fork
      feed(1'b0, 6, 16'h1000);
      feed(1'b1, 6, 16'h2000);
    join
    drain();
    check("alt_count", 32'(hs_ch.size() - base), 32'd12);
    for (int i = 0; i < 12 && base + i < hs_ch.size(); i++) begin
`ifdef AVG_ARB_STRICT_PRIO_EN
      check("strict_grant", 32'(hs_ch[base + i]), (i < 6) ? 32'd0 : 32'd1);
`else
      check("rr_grant", 32'(hs_ch[base + i]), (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
      if (i > 0) check("hs_spacing", 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 32'd3);
    end

    // Flush from IDLE, then warm ch1 past the window depth.
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    check("idle_flush_no_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(negedge clk);
    check("idle_flush_clr", 32'(avg_clr_o), 32'd1);
    feed(1'b1, 130, 16'h0300);
    drain();
    feed(1'b0, 1, 16'h0400);
    drain();

    // Flush during LOAD: in-flight sample completes, then one clear cycle.
    @(posedge clk); #1;
    req1_data_i = 16'h0555; req1_valid_i = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req1_ready_o && t < 20);
    check("flush_hs_ready", 32'(req1_ready_o), 32'd1);
    @(posedge clk); #1 req1_valid_i = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush_res_valid", 32'(res_valid_o), 32'd1);
    check("flush_res_no_clr", 32'(avg_clr_o), 32'd0);
    check("flush_pend_no_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
    @(negedge clk);
    check("flush_clr", 32'(avg_clr_o), 32'd1);
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(negedge clk);
    check("flush_clr_one_cycle", 32'(avg_clr_o), 32'd0);
    feed(1'b1, 1, 16'h0666);
    drain();
    feed(1'b0, 1, 16'h0123);
    drain();

    // Reset asserted in START aborts the sample.
    @(posedge clk); #1;
    req0_data_i = 16'h0777; req0_valid_i = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req0_ready_o && t < 20);
    @(posedge clk); #1 req0_valid_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    if (sb.size() != 0) void'(sb.pop_back());
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(negedge clk);
    check_reset_outputs("rst_start");
    repeat (2) @(negedge clk);
    check("rst_hold_no_valid", 32'(res_valid_o), 32'd0);
    release_reset();

    // First contention after reset goes to ch0.
    base = hs_ch.size();
    @(posedge clk); #1;
    fork
      feed(1'b0, 2, 16'h3000);
      feed(1'b1, 2, 16'h4000);
    join
    drain();
    check("post_rst_count", 32'(hs_ch.size() - base), 32'd4);
    if (hs_ch.size() >= base + 2) begin
      check("post_rst_first", 32'(hs_ch[base]), 32'd0);
`ifdef AVG_ARB_STRICT_PRIO_EN
      check("post_rst_second", 32'(hs_ch[base + 1]), 32'd0);
`else
      check("post_rst_second", 32'(hs_ch[base + 1]), 32'd1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
